huffman_decoder: RTL and testbench
==================================

# huffman_decoder

Receive-side counterpart of the 6-symbol Huffman encoder. Captures the code table (HC1..HC6 codes, M1..M6 masks) when `code_valid` pulses, then decodes a serial MSB-first bitstream into symbol indices 1..6, one registered symbol pulse per completed codeword. Sits downstream of the encoder's table outputs and the bitstream serializer. Flags unmatched or truncated codewords.

## Interface
Parameters:
- `CODE_W`, 8: code/mask width; maximum codeword length.
- `CNT_W`, 16: width of the decoded-symbol counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `code_valid` in 1: one-cycle strobe; HC1..HC6/M1..M6 valid and captured this cycle.
- `HC1`..`HC6` in CODE_W each: codeword for symbol i, right-aligned.
- `M1`..`M6` in CODE_W each: length mask; contiguous ones from bit 0, length L_i = popcount.
- `bit_valid` in 1: serial bit offered.
- `bit_in` in 1: serial bit; each codeword is sent MSB first (HC_i[L_i-1] first).
- `bit_last` in 1: qualifies `bit_in` as the final bit of the stream.
- `bit_ready` out 1: registered; high only in DECODE.
- `sym_valid` out 1: one-cycle pulse, decoded symbol available.
- `sym_out` out 3: symbol index 1..6, held until the next `sym_valid`.
- `err` out 1: one-cycle pulse on a decode error.
- `dec_cnt` out CNT_W: symbols decoded since the last table load; wraps modulo 2^CNT_W.

## Operation
- States: EMPTY (no table), DECODE, HALT (after error or `bit_last`).
- Reset: state EMPTY. `bit_ready`=0, `sym_valid`=0, `sym_out`=0, `err`=0, `dec_cnt`=0. Table registers, `acc`, `len` and `maxlen` are all 0.
- Table load (`code_valid`=1, any state, highest priority):
  - Captures all 12 inputs.
  - Computes `maxlen` = max L_i.
  - Clears `acc` (CODE_W bits) and `len` (4 bits) and `dec_cnt`.
  - Next state is DECODE.
  - A bit offered in the same cycle is discarded and not counted.
- Bit accept: `bit_valid` && `bit_ready`.
  - Next values: `acc_n` = {acc[CODE_W-2:0], bit_in}, `len_n` = len+1.
- Match for symbol i: L_i == `len_n`, L_i != 0, and (HC_i & M_i) == (`acc_n` & M_i).
  - If several symbols match, the lowest index wins.
  - A mask of 0 never matches.
- On match:
  - `sym_out` <= i, `sym_valid` <= 1.
  - `acc`, `len` <= 0.
  - `dec_cnt` += 1, wrapping.
- No match and `len_n` < `maxlen`: store `acc_n` and `len_n`, no output.
- No match and `len_n` >= `maxlen`: `err` <= 1, clear `acc` and `len`, go to HALT.
- `bit_last` on an accepted bit:
  - If it completes a match, the symbol is emitted normally. Otherwise `err` <= 1.
  - Either way, go to HALT.
- HALT: `bit_ready`=0, bits ignored. Exit only via `code_valid` (to DECODE) or `reset`.
- EMPTY: `bit_ready`=0, `bit_valid` ignored. `maxlen`=0 in this state, so no spurious errors occur.
- Table with all masks 0: the first accepted bit gives `len_n`=1 >= `maxlen`=0, so `err` fires and the block goes to HALT.

## Timing
- One bit per cycle throughput; back-to-back codewords need no gap cycles.
- Latency: the bit accepted at edge t that completes a codeword produces `sym_valid`=1 in cycle t+1, for exactly one cycle.
- `err` has the same t+1 latency as `sym_valid`. A match and an error are mutually exclusive for a given bit.
- `bit_ready`:
  - Rises the cycle after the `code_valid` edge.
  - Falls the cycle after the error or `bit_last` edge.
- `dec_cnt` updates on the same edge that sets `sym_valid`.
- `reset` overrides everything, including a same-cycle `code_valid`. Reset mid-codeword discards the partial `acc`.
- `code_valid` mid-codeword discards the partial codeword. No `err` is raised.

## Test plan
Table T used below: HC1..HC6 = 01,01,01,01,01,00 (hex); M1..M6 = 01,03,07,0F,1F,1F.

- Load T, then bits 1,0,1,0,0,0,0,0 on consecutive cycles:
  - `sym_valid` pulses at cycles 1, 3 and 8 after the first bit edge.
  - `sym_out` = 1, 2, 6.
  - `dec_cnt` = 3.
- Load T, then stream 0001 00001 001 with `bit_last` on the final bit:
  - Symbols 4, 5, 3 are decoded.
  - `bit_ready` falls one cycle after the last bit.
  - No `err`.
- Load T with M6=00, then 5 zero bits:
  - `err` pulses one cycle after the 5th bit.
  - No `sym_valid`; `bit_ready`=0.
  - A following `code_valid` restores `bit_ready`=1.
- Load T, send 0,0 with `bit_last` on the second 0:
  - `err`=1 and no symbol.
  - State HALT; further `bit_valid` is ignored.
- Load T, send 0,0,0, then `code_valid` with table T again together with `bit_valid`=1, then bit 1:
  - `sym_out`=1.
  - The partial codeword and the concurrent bit are dropped.
  - `dec_cnt`=1.
- Assert `reset` during decode:
  - All outputs are 0 the next cycle; `bit_ready`=0 until a new `code_valid`.
  - Also: 65536 decoded symbols give `dec_cnt` = 0 (wrap).

Source files
------------

// File: rtl/huffman_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : huffman_decoder
//  Purpose  : Serial MSB-first decoder for a 6-symbol Huffman code. Captures
//             the code/mask table on code_valid, then emits one registered
//             symbol pulse per completed codeword and flags unmatched or
//             truncated codewords.
//  Revision : 1.0 - initial release
// ============================================================================
module huffman_decoder #(
    parameter int CODE_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              code_valid,
    input  logic [CODE_W-1:0] HC1,
    input  logic [CODE_W-1:0] HC2,
    input  logic [CODE_W-1:0] HC3,
    input  logic [CODE_W-1:0] HC4,
    input  logic [CODE_W-1:0] HC5,
    input  logic [CODE_W-1:0] HC6,
    input  logic [CODE_W-1:0] M1,
    input  logic [CODE_W-1:0] M2,
    input  logic [CODE_W-1:0] M3,
    input  logic [CODE_W-1:0] M4,
    input  logic [CODE_W-1:0] M5,
    input  logic [CODE_W-1:0] M6,
    input  logic              bit_valid,
    input  logic              bit_in,
    input  logic              bit_last,
    output logic              bit_ready,
    output logic              sym_valid,
    output logic [2:0]        sym_out,
    output logic              err,
    output logic [CNT_W-1:0]  dec_cnt
);

    localparam int c_NSYM  = 6;
    localparam int c_LEN_W = 4;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_DECODE = 2'd1,
        ST_HALT   = 2'd2
    } state_t;

    // Codeword length of a contiguous mask is its population count
    function automatic logic [c_LEN_W-1:0] popcount(input logic [CODE_W-1:0] v);
        logic [c_LEN_W-1:0] c;
        c = '0;
        for (int b = 0; b < CODE_W; b++) begin
            c = c + {{(c_LEN_W-1){1'b0}}, v[b]};
        end
        return c;
    endfunction

    state_t              r_state;
    state_t              w_state_nx;
    logic [CODE_W-1:0]   r_hc   [c_NSYM];
    logic [CODE_W-1:0]   r_m    [c_NSYM];
    logic [c_LEN_W-1:0]  r_l    [c_NSYM];
    logic [c_LEN_W-1:0]  r_maxlen;
    logic [CODE_W-1:0]   r_acc;
    logic [c_LEN_W-1:0]  r_len;
    logic                r_bit_ready;
    logic                r_sym_valid;
    logic [2:0]          r_sym_out;
    logic                r_err;
    logic [CNT_W-1:0]    r_dec_cnt;

    logic [CODE_W-1:0]   w_hc_in  [c_NSYM];
    logic [CODE_W-1:0]   w_m_in   [c_NSYM];
    logic [c_LEN_W-1:0]  w_l_in   [c_NSYM];
    logic [c_LEN_W-1:0]  w_maxlen_in;
    logic [CODE_W-1:0]   w_acc_sh;
    logic [c_LEN_W-1:0]  w_len_inc;
    logic                w_match;
    logic [2:0]          w_match_sym;
    logic [CODE_W-1:0]   w_acc_nx;
    logic [c_LEN_W-1:0]  w_len_nx;
    logic                w_sym_valid_nx;
    logic [2:0]          w_sym_out_nx;
    logic                w_err_nx;
    logic [CNT_W-1:0]    w_dec_cnt_nx;

    assign w_hc_in[0] = HC1;
    assign w_hc_in[1] = HC2;
    assign w_hc_in[2] = HC3;
    assign w_hc_in[3] = HC4;
    assign w_hc_in[4] = HC5;
    assign w_hc_in[5] = HC6;
    assign w_m_in[0]  = M1;
    assign w_m_in[1]  = M2;
    assign w_m_in[2]  = M3;
    assign w_m_in[3]  = M4;
    assign w_m_in[4]  = M5;
    assign w_m_in[5]  = M6;

    // Lengths and longest codeword of the table being offered for load
    always_comb begin
        w_maxlen_in = '0;
        for (int i = 0; i < c_NSYM; i++) begin
            w_l_in[i] = popcount(w_m_in[i]);
            if (w_l_in[i] > w_maxlen_in) begin
                w_maxlen_in = w_l_in[i];
            end
        end
    end

    assign w_acc_sh  = {r_acc[CODE_W-2:0], bit_in};
    assign w_len_inc = r_len + {{(c_LEN_W-1){1'b0}}, 1'b1};

    // Match search; scanning high to low lets the lowest index win
    always_comb begin
        w_match     = 1'b0;
        w_match_sym = '0;
        for (int i = c_NSYM - 1; i >= 0; i--) begin
            if ((r_l[i] == w_len_inc) && (r_l[i] != '0) &&
                (((r_hc[i] ^ w_acc_sh) & r_m[i]) == '0)) begin
                w_match     = 1'b1;
                w_match_sym = 3'(i + 1);
            end
        end
    end

    // Next-state and datapath decisions; table load outranks bit handling
    always_comb begin
        w_state_nx     = r_state;
        w_acc_nx       = r_acc;
        w_len_nx       = r_len;
        w_sym_valid_nx = 1'b0;
        w_sym_out_nx   = r_sym_out;
        w_err_nx       = 1'b0;
        w_dec_cnt_nx   = r_dec_cnt;
        if (code_valid) begin
            w_state_nx   = ST_DECODE;
            w_acc_nx     = '0;
            w_len_nx     = '0;
            w_dec_cnt_nx = '0;
        end else if (bit_valid && r_bit_ready) begin
            if (w_match) begin
                w_sym_valid_nx = 1'b1;
                w_sym_out_nx   = w_match_sym;
                w_acc_nx       = '0;
                w_len_nx       = '0;
                w_dec_cnt_nx   = r_dec_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                if (bit_last) begin
                    w_state_nx = ST_HALT;
                end
            end else if (bit_last || (w_len_inc >= r_maxlen)) begin
                w_err_nx   = 1'b1;
                w_acc_nx   = '0;
                w_len_nx   = '0;
                w_state_nx = ST_HALT;
            end else begin
                w_acc_nx = w_acc_sh;
                w_len_nx = w_len_inc;
            end
        end
    end

    // State, table and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_EMPTY;
            r_maxlen    <= '0;
            r_acc       <= '0;
            r_len       <= '0;
            r_bit_ready <= 1'b0;
            r_sym_valid <= 1'b0;
            r_sym_out   <= '0;
            r_err       <= 1'b0;
            r_dec_cnt   <= '0;
            for (int i = 0; i < c_NSYM; i++) begin
                r_hc[i] <= '0;
                r_m[i]  <= '0;
                r_l[i]  <= '0;
            end
        end else begin
            if (code_valid) begin
                r_maxlen <= w_maxlen_in;
                for (int i = 0; i < c_NSYM; i++) begin
                    r_hc[i] <= w_hc_in[i];
                    r_m[i]  <= w_m_in[i];
                    r_l[i]  <= w_l_in[i];
                end
            end
            r_state     <= w_state_nx;
            r_acc       <= w_acc_nx;
            r_len       <= w_len_nx;
            r_bit_ready <= (w_state_nx == ST_DECODE);
            r_sym_valid <= w_sym_valid_nx;
            r_sym_out   <= w_sym_out_nx;
            r_err       <= w_err_nx;
            r_dec_cnt   <= w_dec_cnt_nx;
        end
    end

    assign bit_ready = r_bit_ready;
    assign sym_valid = r_sym_valid;
    assign sym_out   = r_sym_out;
    assign err       = r_err;
    assign dec_cnt   = r_dec_cnt;

endmodule
`default_nettype wire

// File: tb/tb_huffman_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_huffman_decoder
//  Purpose  : Directed self-checking bench for huffman_decoder using table T
//             (HC=01,01,01,01,01,00  M=01,03,07,0F,1F,1F).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_huffman_decoder;

    logic        clk;
    logic        reset;
    logic        code_valid;
    logic [7:0]  HC1, HC2, HC3, HC4, HC5, HC6;
    logic [7:0]  M1, M2, M3, M4, M5, M6;
    logic        bit_valid;
    logic        bit_in;
    logic        bit_last;
    logic        bit_ready;
    logic        sym_valid;
    logic [2:0]  sym_out;
    logic        err;
    logic [15:0] dec_cnt;

    int checks   = 0;
    int failures = 0;

    huffman_decoder #(.CODE_W(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .code_valid(code_valid),
        .HC1(HC1), .HC2(HC2), .HC3(HC3), .HC4(HC4), .HC5(HC5), .HC6(HC6),
        .M1(M1), .M2(M2), .M3(M3), .M4(M4), .M5(M5), .M6(M6),
        .bit_valid(bit_valid), .bit_in(bit_in), .bit_last(bit_last),
        .bit_ready(bit_ready), .sym_valid(sym_valid), .sym_out(sym_out),
        .err(err), .dec_cnt(dec_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are then settled from the edge just passed
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_table(input logic [7:0] m6);
        HC1 = 8'h01; HC2 = 8'h01; HC3 = 8'h01; HC4 = 8'h01; HC5 = 8'h01; HC6 = 8'h00;
        M1 = 8'h01; M2 = 8'h03; M3 = 8'h07; M4 = 8'h0F; M5 = 8'h1F; M6 = m6;
    endtask

    task automatic load_table(input logic [7:0] m6);
        set_table(m6);
        code_valid = 1'b1;
        step();
        code_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if ({bit_ready, sym_valid, sym_out, err, dec_cnt} !== 22'd0) begin
            failures++;
            $display("FAIL reset_outputs: got rdy=%b v=%b sym=%0d err=%b cnt=%0d, need all 0",
                     bit_ready, sym_valid, sym_out, err, dec_cnt);
        end
        reset = 1'b0;
        bit_valid = 1'b1; bit_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (bit_ready !== 1'b0 || sym_valid !== 1'b0 || err !== 1'b0) begin
                failures++;
                $display("FAIL empty_ignore[%0d]: got rdy=%b v=%b err=%b, need 0 0 0",
                         k, bit_ready, sym_valid, err);
            end
        end
        bit_valid = 1'b0;
    endtask

    task automatic test_decode_basic();
        logic [7:0] bits;
        logic [7:0] exp_v;
        logic [2:0] exp_s [8];
        bits  = 8'b1010_0000;
        exp_v = 8'b1010_0001;
        exp_s = '{3'd1, 3'd0, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd6};
        load_table(8'h1F);
        checks++;
        if (bit_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_ready: got %b need 1", bit_ready);
        end
        for (int k = 0; k < 8; k++) begin
            bit_valid = 1'b1;
            bit_in = bits[7-k];
            step();
            checks++;
            if (sym_valid !== exp_v[7-k] || err !== 1'b0 ||
                (exp_v[7-k] && sym_out !== exp_s[k])) begin
                failures++;
                $display("FAIL basic_bit[%0d]: got v=%b sym=%0d err=%b, need v=%b sym=%0d err=0",
                         k, sym_valid, sym_out, err, exp_v[7-k], exp_s[k]);
            end
        end
        bit_valid = 1'b0;
        checks++;
        if (dec_cnt !== 16'd3) begin
            failures++;
            $display("FAIL basic_cnt: got %0d need 3", dec_cnt);
        end
    endtask

    task automatic test_last_stream();
        logic [11:0] bits;
        logic [11:0] exp_v;
        logic [2:0]  exp_s [12];
        bits  = 12'b0001_0000_1001;
        exp_v = 12'b0001_0000_1001;
        exp_s = '{3'd0, 3'd0, 3'd0, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0, 3'd5, 3'd0, 3'd0, 3'd3};
        load_table(8'h1F);
        for (int k = 0; k < 12; k++) begin
            bit_valid = 1'b1;
            bit_in = bits[11-k];
            bit_last = (k == 11);
            step();
            checks++;
            if (sym_valid !== exp_v[11-k] || err !== 1'b0 ||
                (exp_v[11-k] && sym_out !== exp_s[k])) begin
                failures++;
                $display("FAIL last_bit[%0d]: got v=%b sym=%0d err=%b, need v=%b sym=%0d err=0",
                         k, sym_valid, sym_out, err, exp_v[11-k], exp_s[k]);
            end
        end
        bit_valid = 1'b0; bit_last = 1'b0;
        checks++;
        if (bit_ready !== 1'b0 || dec_cnt !== 16'd3) begin
            failures++;
            $display("FAIL last_halt: got rdy=%b cnt=%0d, need rdy=0 cnt=3", bit_ready, dec_cnt);
        end
    endtask

    task automatic test_mask_zero_err();
        load_table(8'h00);
        for (int k = 0; k < 5; k++) begin
            bit_valid = 1'b1; bit_in = 1'b0;
            step();
            checks++;
            if (err !== (k == 4) || sym_valid !== 1'b0) begin
                failures++;
                $display("FAIL m6zero_bit[%0d]: got err=%b v=%b, need err=%b v=0",
                         k, err, sym_valid, (k == 4));
            end
        end
        bit_valid = 1'b0;
        checks++;
        if (bit_ready !== 1'b0) begin
            failures++;
            $display("FAIL m6zero_ready: got %b need 0", bit_ready);
        end
        load_table(8'h1F);
        checks++;
        if (bit_ready !== 1'b1) begin
            failures++;
            $display("FAIL reload_ready: got %b need 1", bit_ready);
        end
    endtask

    task automatic test_truncated();
        load_table(8'h1F);
        bit_valid = 1'b1; bit_in = 1'b0; bit_last = 1'b0;
        step();
        bit_last = 1'b1;
        step();
        checks++;
        if (err !== 1'b1 || sym_valid !== 1'b0) begin
            failures++;
            $display("FAIL trunc_err: got err=%b v=%b, need err=1 v=0", err, sym_valid);
        end
        bit_last = 1'b0; bit_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (err !== 1'b0 || sym_valid !== 1'b0 || bit_ready !== 1'b0) begin
                failures++;
                $display("FAIL halt_ignore[%0d]: got err=%b v=%b rdy=%b, need 0 0 0",
                         k, err, sym_valid, bit_ready);
            end
        end
        bit_valid = 1'b0;
    endtask

    task automatic test_reload_mid();
        load_table(8'h1F);
        bit_valid = 1'b1; bit_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (sym_valid !== 1'b0 || err !== 1'b0) begin
                failures++;
                $display("FAIL reload_pre[%0d]: got v=%b err=%b, need 0 0", k, sym_valid, err);
            end
        end
        bit_in = 1'b1;
        load_table(8'h1F);
        checks++;
        if (sym_valid !== 1'b0 || err !== 1'b0 || dec_cnt !== 16'd0 || bit_ready !== 1'b1) begin
            failures++;
            $display("FAIL reload_load: got v=%b err=%b cnt=%0d rdy=%b, need 0 0 0 1",
                     sym_valid, err, dec_cnt, bit_ready);
        end
        step();
        checks++;
        if (sym_valid !== 1'b1 || sym_out !== 3'd1 || dec_cnt !== 16'd1 || err !== 1'b0) begin
            failures++;
            $display("FAIL reload_sym: got v=%b sym=%0d cnt=%0d err=%b, need 1 1 1 0",
                     sym_valid, sym_out, dec_cnt, err);
        end
        bit_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        load_table(8'h1F);
        bit_valid = 1'b1; bit_in = 1'b0;
        step();
        reset = 1'b1;
        set_table(8'h1F);
        code_valid = 1'b1;
        bit_in = 1'b1;
        step();
        checks++;
        if ({bit_ready, sym_valid, sym_out, err, dec_cnt} !== 22'd0) begin
            failures++;
            $display("FAIL midreset_outputs: got rdy=%b v=%b sym=%0d err=%b cnt=%0d, need all 0",
                     bit_ready, sym_valid, sym_out, err, dec_cnt);
        end
        reset = 1'b0; code_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if (bit_ready !== 1'b0 || sym_valid !== 1'b0) begin
                failures++;
                $display("FAIL midreset_idle[%0d]: got rdy=%b v=%b, need 0 0", k, bit_ready, sym_valid);
            end
        end
        bit_valid = 1'b0;
    endtask

    task automatic test_cnt_wrap();
        load_table(8'h1F);
        bit_valid = 1'b1; bit_in = 1'b1;
        repeat (65535) step();
        checks++;
        if (dec_cnt !== 16'hFFFF) begin
            failures++;
            $display("FAIL wrap_pre: got %0d need 65535", dec_cnt);
        end
        step();
        checks++;
        if (dec_cnt !== 16'd0 || sym_valid !== 1'b1 || sym_out !== 3'd1) begin
            failures++;
            $display("FAIL wrap_zero: got cnt=%0d v=%b sym=%0d, need 0 1 1", dec_cnt, sym_valid, sym_out);
        end
        bit_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; code_valid = 1'b0;
        bit_valid = 1'b0; bit_in = 1'b0; bit_last = 1'b0;
        HC1 = '0; HC2 = '0; HC3 = '0; HC4 = '0; HC5 = '0; HC6 = '0;
        M1 = '0; M2 = '0; M3 = '0; M4 = '0; M5 = '0; M6 = '0;
        test_reset();
        test_decode_basic();
        test_last_stream();
        test_mask_zero_err();
        test_truncated();
        test_reload_mid();
        test_reset_mid();
        test_cnt_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
